// File: rtl/referee.sv
// ============================================================================
//  Module   : referee
//  Purpose  : Reaction-game referee: random lights-off delay, go-lights, and
//             first-push judging with alternating tie priority.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module referee #(
  parameter int TICK       = 1000,
  parameter int BASE_TICKS = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic pbl,
  input  logic pbr,
  input  logic gameover,
  output logic leds_on,
  output logic winrnd,
  output logic right
);

  localparam int              c_PRESC_W   = (TICK > 2) ? $clog2(TICK) : 1;
  localparam logic [c_PRESC_W-1:0] c_TICK_LAST = c_PRESC_W'(TICK - 1);
  localparam logic [c_PRESC_W-1:0] c_PRESC_ONE = c_PRESC_W'(1);
  localparam logic [8:0]      c_BASE      = 9'(BASE_TICKS);

  typedef enum logic [1:0] {
    RELEASE = 2'd0,
    DELAY   = 2'd1,
    LIGHTS  = 2'd2,
    RESULT  = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_pbl_meta;
  logic                 r_pbr_meta;
  logic                 r_sl;
  logic                 r_sr;
  logic                 r_push_l;
  logic                 r_push_r;
  logic [7:0]           r_lfsr;
  logic                 r_prio;
  logic [8:0]           r_dcnt;
  logic [c_PRESC_W-1:0] r_presc;

  logic w_fb;
  logic w_push_any;
  logic w_tie;
  logic w_winner;
  logic w_tick_done;
  logic w_delay_done;

  // Buttons are asynchronous to clk; only the second flop is ever observed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pbl_meta <= 1'b0;
      r_pbr_meta <= 1'b0;
      r_sl       <= 1'b0;
      r_sr       <= 1'b0;
    end else begin
      r_pbl_meta <= pbl;
      r_pbr_meta <= pbr;
      r_sl       <= r_pbl_meta;
      r_sr       <= r_pbr_meta;
    end
  end

  // Judging stage: both synchronized levels are sampled together so a tie is
  // decided on one common registered snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_push_l <= 1'b0;
      r_push_r <= 1'b0;
    end else begin
      r_push_l <= r_sl;
      r_push_r <= r_sr;
    end
  end

  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= 8'h01;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_fb};
    end
  end

  assign w_push_any   = r_push_l | r_push_r;
  assign w_tie        = r_push_l & r_push_r;
  assign w_winner     = w_tie ? r_prio : r_push_r;
  assign w_tick_done  = (r_presc == c_TICK_LAST);
  assign w_delay_done = w_tick_done && (r_dcnt == 9'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RELEASE;
      leds_on <= 1'b0;
      winrnd  <= 1'b0;
      right   <= 1'b0;
      r_prio  <= 1'b0;
      r_dcnt  <= 9'd0;
      r_presc <= '0;
    end else begin
      winrnd <= 1'b0;
      case (r_state)
        RELEASE: begin
          leds_on <= 1'b0;
          if (!w_push_any && !gameover) begin
            r_state <= DELAY;
            r_dcnt  <= c_BASE + {1'b0, r_lfsr};
            r_presc <= '0;
          end
        end

        DELAY: begin
          if (gameover) begin
            r_state <= RELEASE;
            leds_on <= 1'b0;
          end else if (w_push_any) begin
            r_state <= RESULT;
            winrnd  <= 1'b1;
            right   <= w_winner;
            leds_on <= 1'b0;
            if (w_tie) begin
              r_prio <= ~r_prio;
            end
          end else if (w_tick_done) begin
            r_presc <= '0;
            r_dcnt  <= r_dcnt - 9'd1;
            if (w_delay_done) begin
              r_state <= LIGHTS;
              leds_on <= 1'b1;
            end
          end else begin
            r_presc <= r_presc + c_PRESC_ONE;
          end
        end

        LIGHTS: begin
          if (gameover) begin
            r_state <= RELEASE;
            leds_on <= 1'b0;
          end else if (w_push_any) begin
            r_state <= RESULT;
            winrnd  <= 1'b1;
            right   <= w_winner;
            if (w_tie) begin
              r_prio <= ~r_prio;
            end
          end
        end

        RESULT: begin
          // gameover is deliberately ignored here so the judged pulse is never cut.
          r_state <= RELEASE;
          leds_on <= 1'b0;
        end

        default: begin
          r_state <= RELEASE;
          leds_on <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_referee.sv
// ============================================================================
//  Module   : tb_referee
//  Purpose  : Randomized scoreboard bench for referee (TICK=4, BASE_TICKS=2).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_referee;

  localparam int TICK = 4;
  localparam int BASE = 2;

  localparam logic [1:0] EV_WIN  = 2'd0;
  localparam logic [1:0] EV_UP   = 2'd1;
  localparam logic [1:0] EV_DOWN = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] at;
    logic        rgt;
    logic        led;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pbl = 1'b0;
  logic pbr = 1'b0;
  logic gameover = 1'b0;
  logic leds_on;
  logic winrnd;
  logic right;

  referee #(.TICK(TICK), .BASE_TICKS(BASE)) dut (
    .clk(clk), .rst(rst), .pbl(pbl), .pbr(pbr), .gameover(gameover),
    .leds_on(leds_on), .winrnd(winrnd), .right(right)
  );

  always #5 clk = ~clk;

  // Edge number since the last reset release: in the cycle after edge n, cyc == n.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  ev_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] lf [0:254];
  int         s_rel;
  int         j_low;
  int         gl_edge;
  logic       prio;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic expect_ev(input logic [1:0] kind, input int at, input logic rgt, input logic led);
    ev_t e;
    e.kind = kind; e.at = 32'(at); e.rgt = rgt; e.led = led;
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%b required=%b at cyc=%0d", name, got, want, cyc);
    end
  endtask

  task automatic compare(input ev_t got);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event got kind=%0d cyc=%0d right=%b leds=%b required none",
               got.kind, got.at, got.rgt, got.led);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL event got kind=%0d cyc=%0d right=%b leds=%b required kind=%0d cyc=%0d right=%b leds=%b",
                 got.kind, got.at, got.rgt, got.led, e.kind, e.at, e.rgt, e.led);
      end
    end
  endtask

  // Drive point: called to act in the cycle after edge n, i.e. before edge n+1.
  task automatic wait_at(input int n);
    if (cyc > n) begin
      failures++;
      $display("FAIL schedule got cyc=%0d required<=%0d", cyc, n);
    end
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every leds_on change and every winrnd pulse must match the queue head.
  initial begin
    logic prev;
    ev_t  got;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if (leds_on !== prev) begin
          got.kind = leds_on ? EV_UP : EV_DOWN;
          got.at = 32'(cyc); got.rgt = 1'b0; got.led = leds_on;
          compare(got);
        end
        if (winrnd !== 1'b0) begin
          got.kind = EV_WIN; got.at = 32'(cyc); got.rgt = right; got.led = leds_on;
          compare(got);
        end
        prev = leds_on;
      end
    end
  end

  // mode 0: push in LIGHTS, 1: push in DELAY, 2: gameover anywhere in the round,
  // 3: push and gameover judged on the same LIGHTS edge, 4: gameover in LIGHTS.
  // side 0: left, 1: right, 2: both on the same edge.
  task automatic do_round(input int mode, input int side, input int dly, input int hold, input int rnd);
    int   entry, lval, lights, k, w, g, lo, hi;
    logic win;
    entry  = imax(s_rel + 1, imax(j_low + 3, gl_edge));
    lval   = int'(lf[(entry - 1) % 255]);
    lights = entry + (BASE + lval) * TICK;
    win    = (side == 2) ? prio : (side == 1);
    case (mode)
      0, 1: begin
        if (mode == 0) begin
          w = lights + dly;
          k = w - 3;
          expect_ev(EV_UP, lights, 1'b0, 1'b1);
          expect_ev(EV_WIN, w, win, 1'b1);
          expect_ev(EV_DOWN, w + 1, 1'b0, 1'b0);
        end else begin
          lo = imax(entry - 2, cyc + 1);
          hi = lights - 4;
          k  = lo + (rnd % (hi - lo + 1));
          w  = k + 3;
          expect_ev(EV_WIN, w, win, 1'b0);
        end
        if (side == 2) prio = ~prio;
        wait_at(k - 1);
        pbl = (side != 1);
        pbr = (side != 0);
        wait_at(w + hold - 1);
        pbl = 1'b0;
        pbr = 1'b0;
        s_rel = w + 1;
        j_low = w + hold;
      end
      2, 4: begin
        g = (mode == 4) ? lights + dly : entry + 1 + (rnd % (lights + 5 - entry));
        if (g > lights) begin
          expect_ev(EV_UP, lights, 1'b0, 1'b1);
          expect_ev(EV_DOWN, g, 1'b0, 1'b0);
        end
        wait_at(g - 1);
        gameover = 1'b1;
        wait_at(g + hold % 3);
        gameover = 1'b0;
        s_rel   = g;
        gl_edge = g + 1 + hold % 3;
      end
      default: begin
        g = lights + dly;
        k = g - 3;
        expect_ev(EV_UP, lights, 1'b0, 1'b1);
        expect_ev(EV_DOWN, g, 1'b0, 1'b0);
        wait_at(k - 1);
        pbl = (side != 1);
        pbr = (side != 0);
        wait_at(g - 1);
        gameover = 1'b1;
        wait_at(g);
        gameover = 1'b0;
        wait_at(g + hold - 1);
        pbl = 1'b0;
        pbr = 1'b0;
        s_rel   = g;
        gl_edge = g + 1;
        j_low   = g + hold;
      end
    endcase
  endtask

  task automatic reset_in_result();
    int entry, lval, lights, k, w;
    entry  = imax(s_rel + 1, imax(j_low + 3, gl_edge));
    lval   = int'(lf[(entry - 1) % 255]);
    lights = entry + (BASE + lval) * TICK;
    k = imax(entry - 2, cyc + 1) + 3;
    if (k > lights - 4) k = lights - 4;
    w = k + 3;
    wait_at(k - 1);
    pbr = 1'b1;
    wait_at(w);
    check_val("win_before_rst", winrnd, 1'b1);
    rst = 1'b1;
    #1;
    check_val("rst_winrnd", winrnd, 1'b0);
    check_val("rst_leds", leds_on, 1'b0);
    check_val("rst_right", right, 1'b0);
    pbr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    s_rel = 0; j_low = -2; gl_edge = 1; prio = 1'b0;
  endtask

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog got cyc=%0d required completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    lf[0] = 8'h01;
    for (int i = 0; i < 254; i++)
      lf[i+1] = {lf[i][6:0], lf[i][7] ^ lf[i][5] ^ lf[i][4] ^ lf[i][3]};
    s_rel = 0; j_low = -2; gl_edge = 1; prio = 1'b0;

    #12;
    check_val("reset_leds", leds_on, 1'b0);
    check_val("reset_winrnd", winrnd, 1'b0);
    check_val("reset_right", right, 1'b0);
    #10;
    rst = 1'b0;

    do_round(0, 1, 4, 1, 0);    // right push in LIGHTS, lights expected at edge 13
    do_round(1, 0, 1, 2, 7);    // jump-the-light push by left
    do_round(0, 2, 3, 2, 0);    // tie in LIGHTS -> right=0
    do_round(1, 2, 1, 1, 3);    // tie in DELAY  -> right=1
    do_round(0, 1, 2, 20, 0);   // right held long after the result
    do_round(4, 0, 2, 1, 0);    // gameover in LIGHTS
    do_round(3, 1, 3, 2, 0);    // push ignored under gameover

    for (int r = 0; r < 18; r++)
      do_round($urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(1, 6),
               $urandom_range(1, 6), $urandom_range(0, 100000));

    reset_in_result();
    do_round(0, 0, 2, 1, 0);    // fresh sequence again: lights at edge 13

    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_events got pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
